ln_seq: RTL
===========

# ln_seq

Sequential natural-logarithm unit for the sign-magnitude Q16.16 fixed-point library. It is the inverse of the `exp` / `exp_higher_precision` blocks. One operand is accepted over a valid/ready handshake. The result is computed as ln(x) = ln2 · log2(x) using leading-one normalisation, followed by Q iterations of bit-serial repeated squaring. Neuron models use it to compute time constants and log-domain quantities without combinational reciprocal chains.

## Interface
- N, 32, total word width; sign bit at N-1, magnitude N-2:0
- Q, 16, fractional bits; also the number of squaring iterations
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- in_valid  input  1  operand present
- in_ready  output  1  block idle, operand accepted when in_valid && in_ready
- in_data  input  N  operand x, sign-magnitude Q16.16
- out_valid  output  1  result available; held until taken
- out_ready  input  1  consumer accepts result
- out_data  output  N  ln(x), sign-magnitude Q16.16
- out_err  output  1  x was non-positive; qualified by out_valid

## Operation
- States: IDLE, NORM, FRAC, SCALE, DONE.
- IDLE:
  - in_ready=1.
  - On handshake, register in_data and go to NORM.
- NORM, 1 cycle:
  - Set the error flag if sign=1 or magnitude=0. This covers both +0 and −0 (0x80000000).
  - Otherwise find the leading-one position p (0..30) of the magnitude.
  - int_part = p − Q, a signed value in −16..14.
  - m = magnitude shifted so the leading one sits at bit 30. m is unsigned Q2.30 in [1,2).
  - Clear the iteration counter and frac.
- FRAC, Q cycles, each cycle:
  - sq = m·m (64-bit); t = sq[61:30].
  - If t[31]=1: the next frac bit is 1 and m ← sq[62:31].
  - Else: the next frac bit is 0 and m ← t.
  - frac fills MSB-first.
  - Leave FRAC after iteration Q−1.
- SCALE, 1 cycle:
  - l2 = {sign-extended int_part, frac}, two's-complement Q16.16.
  - mag = |l2|.
  - r = (mag · LN2 + 2^(Q−1)) >> Q, where LN2 = 0x0000B172. This is round-half-up.
  - out_data = {l2<0 && r≠0, r[N-2:0]}. Negative zero is never produced.
  - On error: out_data = 0xFFFFFFFF and out_err=1. The error result overrides the datapath.
- DONE:
  - out_valid=1; out_data and out_err stable.
  - On out_valid && out_ready, go to IDLE.
- Accuracy: |error| ≤ 2 LSB versus ideal ln(x) for all positive representable x.

## Timing
- Reset values:
  - state = IDLE, so in_ready=1.
  - out_valid = 0, out_data = 0, out_err = 0.
  - All internal registers = 0.
- Latency is fixed and independent of the data or error path:
  - out_valid rises after the (Q+2)th rising edge following the accepting edge, i.e. 18 clocks for Q=16.
- in_ready is low from the cycle after acceptance until the cycle after the result handshake. There are no overlapping operations; the throughput bound is one result per Q+3 clocks.
- Backpressure: out_ready low holds DONE indefinitely, with out_data unchanged.
- in_valid is ignored outside IDLE; in_data is sampled only on the handshake edge.
- Reset asserted mid-operation aborts immediately:
  - Outputs go to their reset values.
  - Nothing is emitted after release.

## Structure
- Package `fixed_pkg` holds:
  - N, Q;
  - the LN2 constant;
  - the error result constant 0xFFFFFFFF;
  - the state enum `ln_state_t`.
- Sub-module `ln_norm` (combinational): a leading-one detector plus barrel shifter, producing int_part and m from the magnitude. It is reusable by a future log2 block.
- The squaring multiplier and the SCALE multiplier are inline; there is no reuse of `mult`, because it truncates to Q16.16.

## Test plan
- x=0x00010000 (1.0) → out_data=0x00000000, out_err=0, out_valid exactly 18 clocks after acceptance.
- x=0x00020000 (2.0) → 0x0000B172 ±2 LSB. x=0x00008000 (0.5) → 0x8000B172 ±2 LSB.
- x=0x0002B7E1 (≈e) → 0x00010000 ±2 LSB. x=0x00000001 → 0x800B1721 ±2 LSB.
- x=0x00000000, 0x80000000 and 0x80010000 → each gives out_data=0xFFFFFFFF, out_err=1, same 18-clock latency.
- out_ready held low 10 cycles in DONE → out_valid and out_data stable, in_ready=0; one clock after the handshake, in_ready=1. Back-to-back requests are then accepted.
- reset pulsed at FRAC iteration 5 → outputs return to reset values immediately, no spurious out_valid; the next operand x=0x00040000 gives 0x000162E4 ±2 LSB.

Source files
------------

// File: rtl/fixed_pkg.sv
// Shared constants and types for the sign-magnitude Q16.16 fixed-point library.
package fixed_pkg;

  localparam int N  = 32;
  localparam int Q  = 16;
  localparam int PW = 5;  // leading-one position width (0..30)
  localparam int IW = 6;  // signed integer part of log2, -16..14

  localparam logic [N-1:0] LN2        = 32'h0000B172;
  localparam logic [N-1:0] ERR_RESULT = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NORM  = 3'd1,
    FRAC  = 3'd2,
    SCALE = 3'd3,
    DONE  = 3'd4
  } ln_state_t;

endpackage

// File: rtl/ln_norm.sv
// Leading-one detector and barrel shifter: splits a magnitude into the integer
// part of log2 and a mantissa normalised to unsigned Q2.30 in [1,2).
module ln_norm
  import fixed_pkg::*;
(
  input  logic        [N-2:0]  mag_i,
  output logic signed [IW-1:0] int_part_o,
  output logic        [N-1:0]  m_o
);

  logic [PW-1:0] pos;
  logic [PW-1:0] shamt;
  logic [N-2:0]  shifted;

  // Ascending scan: the highest set bit is the last one written.
  always_comb begin
    pos = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (mag_i[i]) pos = PW'(i);
    end
  end

  assign shamt      = PW'(N - 2) - pos;
  assign shifted    = mag_i << shamt;
  assign m_o        = {1'b0, shifted};
  assign int_part_o = $signed({1'b0, pos}) - $signed(IW'(Q));

endmodule

// File: rtl/ln_seq.sv
// Sequential ln(x) = ln2 * log2(x): leading-one normalisation, Q rounds of
// bit-serial repeated squaring for the fraction, then one scaling multiply.
module ln_seq
  import fixed_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_err
);

  localparam int CW = $clog2(Q);

  ln_state_t             state_q, state_d;
  logic        [N-1:0]   x_q, x_d;
  logic                  err_q, err_d;
  logic signed [IW-1:0]  int_q, int_d;
  logic        [N-1:0]   m_q, m_d;
  logic        [Q-1:0]   frac_q, frac_d;
  logic        [CW-1:0]  cnt_q, cnt_d;
  logic        [N-1:0]   out_data_q, out_data_d;
  logic                  out_err_q, out_err_d;

  logic signed [IW-1:0]  norm_int;
  logic        [N-1:0]   norm_m;
  logic        [N:0]     sq_hi;
  logic signed [N-1:0]  l2;

  // Round-half-up of |l2| * ln2 back to Q16.16, packed as sign-magnitude.
  // A result that rounds to zero is always emitted as +0.
  function automatic logic [N-1:0] scale_round(input logic signed [N-1:0] v);
    logic           neg;
    logic [N-1:0]   mag;
    logic [N+Q-1:0] prod;
    logic [N-1:0]   r;
    neg  = v[N-1];
    mag  = neg ? $unsigned(-v) : $unsigned(v);
    prod = (N+Q)'(mag) * (N+Q)'(LN2) + ((N+Q)'(1) << (Q - 1));
    r    = N'(prod >> Q);
    return {neg && (r != '0), r[N-2:0]};
  endfunction

  ln_norm u_norm (
    .mag_i      (x_q[N-2:0]),
    .int_part_o (norm_int),
    .m_o        (norm_m)
  );

  // m*m in Q4.60; keep bits 62:30 so both the t and the halved-t views exist.
  assign sq_hi = (N+1)'(((2*N)'(m_q) * (2*N)'(m_q)) >> (N - 2));
  assign l2    = {{(N-Q-IW){int_q[IW-1]}}, int_q, frac_q};

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    err_d      = err_q;
    int_d      = int_q;
    m_d        = m_q;
    frac_d     = frac_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = in_data;
          state_d = NORM;
        end
      end
      NORM: begin
        err_d   = x_q[N-1] || (x_q[N-2:0] == '0);
        int_d   = norm_int;
        m_d     = norm_m;
        cnt_d   = '0;
        frac_d  = '0;
        state_d = FRAC;
      end
      FRAC: begin
        // t >= 2 contributes a 1 bit and is halved back into [1,2).
        if (sq_hi[N-1]) m_d = sq_hi[N:1];
        else            m_d = sq_hi[N-1:0];
        frac_d = {frac_q[Q-2:0], sq_hi[N-1]};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(Q - 1)) state_d = SCALE;
      end
      SCALE: begin
        out_data_d = err_q ? ERR_RESULT : scale_round(l2);
        out_err_d  = err_q;
        state_d    = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      err_q      <= 1'b0;
      int_q      <= '0;
      m_q        <= '0;
      frac_q     <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      err_q      <= err_d;
      int_q      <= int_d;
      m_q        <= m_d;
      frac_q     <= frac_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule
